// File: rtl/d_victim_cache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_def : shared victim-cache types, geometry and controller states     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cache_def;

  localparam int TAGMSB_VC    = 31;
  localparam int TAGLSB_VC    = 4;
  localparam int WAYS_VC      = 8;
  localparam int INDEX_WAY_VC = 3;

  typedef struct packed {
    logic we;
  } vc_cache_req_type;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TAGMSB_VC:TAGLSB_VC] tag;
  } vc_cache_tag_type;

  typedef enum logic [3:0] {
    INIT, IDLE, PROBE, SWAP, INVAL, VSEL, WB, INSERT, RESP
  } vc_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/d_victim_cache_ctrl_repl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | d_victim_cache_repl : victim way select (first free way, else pointer)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module d_victim_cache_repl
  import cache_def::*;
(
  input  logic [WAYS_VC-1:0]      vld_i,
  input  logic [INDEX_WAY_VC-1:0] ptr_i,
  output logic [INDEX_WAY_VC-1:0] way_o,
  output logic                    full_o
);

  always_comb begin
    way_o = ptr_i;
    // Scan from the top so the lowest free way wins.
    for (int i = WAYS_VC - 1; i >= 0; i--) begin
      if (!vld_i[i]) way_o = INDEX_WAY_VC'(i);
    end
  end

  assign full_o = &vld_i;

endmodule
`default_nettype wire

// File: rtl/d_victim_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | d_victim_cache_ctrl : L1 D-cache miss handler for the 8-way victim cache  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module d_victim_cache_ctrl
  import cache_def::*;
#(
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_W     = TAGMSB_VC + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    l1_req_valid_i,
  output logic                    l1_req_ready_o,
  input  logic [ADDR_W-1:0]       l1_req_addr_i,
  input  logic                    l1_vic_valid_i,
  input  logic [ADDR_W-1:0]       l1_vic_addr_i,
  input  logic                    l1_vic_dirty_i,
  input  logic [BLOCK_BITS-1:0]   l1_vic_data_i,
  output logic                    l1_rsp_valid_o,
  output logic                    l1_rsp_hit_o,
  output logic                    l1_rsp_dirty_o,
  output logic [BLOCK_BITS-1:0]   l1_rsp_data_o,
  output vc_cache_req_type        tag_req_o,
  output vc_cache_tag_type        tag_write_o,
  output logic [ADDR_W-1:0]       tag_addr_o,
  output logic [INDEX_WAY_VC-1:0] tag_way_o,
  input  vc_cache_tag_type        tag_read_i,
  input  logic [INDEX_WAY_VC-1:0] tag_way_i,
  input  logic                    tag_full_i,
  output logic                    data_we_o,
  output logic [INDEX_WAY_VC-1:0] data_way_o,
  output logic [BLOCK_BITS-1:0]   data_wdata_o,
  input  logic [BLOCK_BITS-1:0]   data_rdata_i,
  output logic                    mem_wb_valid_o,
  input  logic                    mem_wb_ready_i,
  output logic [ADDR_W-1:0]       mem_wb_addr_o,
  output logic [BLOCK_BITS-1:0]   mem_wb_data_o
);

  vc_ctrl_state_e             r_state;
  logic [INDEX_WAY_VC-1:0]    r_init_cnt, r_repl_ptr, r_way;
  logic [WAYS_VC-1:0]         r_vld_q;
  logic [ADDR_W-1:0]          r_req_addr, r_vic_addr;
  logic                       r_vic_valid, r_vic_dirty, r_hit, r_rsp_dirty;
  logic [BLOCK_BITS-1:0]      r_vic_data, r_rsp_data, r_wb_data;
  logic [TAGMSB_VC:TAGLSB_VC] r_wb_tag;

  logic                    w_hit, w_full;
  logic [INDEX_WAY_VC-1:0] w_sel_way;

  // The tag array hands back a non-matching entry on a miss, so hit is decided here.
  assign w_hit = tag_read_i.valid && (tag_read_i.tag == r_req_addr[TAGMSB_VC:TAGLSB_VC]);

  d_victim_cache_repl u_repl (
    .vld_i  (r_vld_q),
    .ptr_i  (r_repl_ptr),
    .way_o  (w_sel_way),
    .full_o (w_full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_repl_ptr  <= '0;
      r_vld_q     <= '0;
      r_req_addr  <= '0;
      r_vic_addr  <= '0;
      r_vic_valid <= 1'b0;
      r_vic_dirty <= 1'b0;
      r_vic_data  <= '0;
      r_way       <= '0;
      r_hit       <= 1'b0;
      r_rsp_dirty <= 1'b0;
      r_rsp_data  <= '0;
      r_wb_tag    <= '0;
      r_wb_data   <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == INDEX_WAY_VC'(WAYS_VC - 1)) r_state <= IDLE;
        end
        IDLE: begin
          if (l1_req_valid_i) begin
            r_req_addr  <= l1_req_addr_i;
            r_vic_valid <= l1_vic_valid_i;
            r_vic_addr  <= l1_vic_addr_i;
            r_vic_dirty <= l1_vic_dirty_i;
            r_vic_data  <= l1_vic_data_i;
            r_hit       <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_data  <= '0;
            r_state     <= PROBE;
          end
        end
        PROBE: begin
          if (w_hit) begin
            r_way       <= tag_way_i;
            r_hit       <= 1'b1;
            r_rsp_dirty <= tag_read_i.dirty;
            r_rsp_data  <= data_rdata_i;
            r_state     <= r_vic_valid ? SWAP : INVAL;
          end else if (r_vic_valid) begin
            r_way   <= w_sel_way;
            r_state <= VSEL;
          end else begin
            r_state <= RESP;
          end
        end
        SWAP:  r_state <= RESP;
        INVAL: begin
          r_vld_q[r_way] <= 1'b0;
          r_state        <= RESP;
        end
        VSEL: begin
          r_wb_tag  <= tag_read_i.tag;
          r_wb_data <= data_rdata_i;
          r_state   <= (tag_read_i.valid && tag_read_i.dirty) ? WB : INSERT;
        end
        WB: if (mem_wb_ready_i) r_state <= INSERT;
        INSERT: begin
          r_vld_q[r_way] <= 1'b1;
          if (w_full) r_repl_ptr <= r_repl_ptr + 1'b1;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= INIT;
      endcase
    end
  end

  always_comb begin
    l1_req_ready_o = 1'b0;
    l1_rsp_valid_o = 1'b0;
    l1_rsp_hit_o   = 1'b0;
    l1_rsp_dirty_o = 1'b0;
    l1_rsp_data_o  = '0;
    tag_req_o      = '0;
    tag_write_o    = '0;
    tag_addr_o     = '0;
    tag_way_o      = '0;
    data_we_o      = 1'b0;
    data_way_o     = r_way;
    data_wdata_o   = '0;
    mem_wb_valid_o = 1'b0;
    mem_wb_addr_o  = '0;
    mem_wb_data_o  = '0;
    case (r_state)
      INIT: begin
        // Gated so no tag write happens while reset is still held.
        tag_req_o.we = rst_ni;
        tag_way_o    = r_init_cnt;
      end
      IDLE:  l1_req_ready_o = 1'b1;
      PROBE: begin
        tag_addr_o = r_req_addr;
        data_way_o = tag_way_i;
      end
      SWAP, INSERT: begin
        tag_req_o.we      = 1'b1;
        tag_addr_o        = r_vic_addr;
        tag_way_o         = r_way;
        tag_write_o.valid = 1'b1;
        tag_write_o.dirty = r_vic_dirty;
        tag_write_o.tag   = r_vic_addr[TAGMSB_VC:TAGLSB_VC];
        data_we_o         = 1'b1;
        data_wdata_o      = r_vic_data;
      end
      INVAL: begin
        tag_req_o.we = 1'b1;
        tag_addr_o   = r_req_addr;
        tag_way_o    = r_way;
      end
      VSEL: begin
        tag_addr_o = r_vic_addr;
        tag_way_o  = r_way;
      end
      WB: begin
        mem_wb_valid_o = 1'b1;
        mem_wb_addr_o  = ADDR_W'({r_wb_tag, {TAGLSB_VC{1'b0}}});
        mem_wb_data_o  = r_wb_data;
      end
      RESP: begin
        l1_rsp_valid_o = 1'b1;
        l1_rsp_hit_o   = r_hit;
        l1_rsp_dirty_o = r_rsp_dirty;
        l1_rsp_data_o  = r_rsp_data;
      end
      default: ;
    endcase
  end

  a_vic_ne_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == PROBE && r_vic_valid) |->
      (r_vic_addr[TAGMSB_VC:TAGLSB_VC] != r_req_addr[TAGMSB_VC:TAGLSB_VC]));

  a_full_match: assert property (@(posedge clk_i) disable iff (!rst_ni || r_state == INIT)
    (&r_vld_q) |-> tag_full_i);

endmodule
`default_nettype wire

// File: tb/tb_d_victim_cache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_d_victim_cache_ctrl : directed bench with tag/data array models        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_d_victim_cache_ctrl;
  import cache_def::*;

  localparam int BB = 128;
  localparam int AW = TAGMSB_VC + 1;
  localparam int TW = TAGMSB_VC - TAGLSB_VC + 1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic l1_req_valid_i, l1_req_ready_o, l1_vic_valid_i, l1_vic_dirty_i;
  logic [AW-1:0] l1_req_addr_i, l1_vic_addr_i, tag_addr_o, mem_wb_addr_o;
  logic [BB-1:0] l1_vic_data_i, l1_rsp_data_o, data_wdata_o, data_rdata_i, mem_wb_data_o;
  logic l1_rsp_valid_o, l1_rsp_hit_o, l1_rsp_dirty_o;
  vc_cache_req_type tag_req_o;
  vc_cache_tag_type tag_write_o, tag_read_i;
  logic [INDEX_WAY_VC-1:0] tag_way_o, tag_way_i, data_way_o;
  logic tag_full_i, data_we_o, mem_wb_valid_o, mem_wb_ready_i;

  vc_cache_tag_type tag_mem [WAYS_VC];
  logic [BB-1:0]    data_mem [WAYS_VC];
  logic             load_junk;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  d_victim_cache_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .l1_req_valid_i(l1_req_valid_i), .l1_req_ready_o(l1_req_ready_o), .l1_req_addr_i(l1_req_addr_i),
    .l1_vic_valid_i(l1_vic_valid_i), .l1_vic_addr_i(l1_vic_addr_i), .l1_vic_dirty_i(l1_vic_dirty_i),
    .l1_vic_data_i(l1_vic_data_i), .l1_rsp_valid_o(l1_rsp_valid_o), .l1_rsp_hit_o(l1_rsp_hit_o),
    .l1_rsp_dirty_o(l1_rsp_dirty_o), .l1_rsp_data_o(l1_rsp_data_o),
    .tag_req_o(tag_req_o), .tag_write_o(tag_write_o), .tag_addr_o(tag_addr_o), .tag_way_o(tag_way_o),
    .tag_read_i(tag_read_i), .tag_way_i(tag_way_i), .tag_full_i(tag_full_i),
    .data_we_o(data_we_o), .data_way_o(data_way_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .mem_wb_valid_o(mem_wb_valid_o), .mem_wb_ready_i(mem_wb_ready_i),
    .mem_wb_addr_o(mem_wb_addr_o), .mem_wb_data_o(mem_wb_data_o)
  );

  // Fully-associative tag array: compare on tag_addr_o, fall back to tag_way_o.
  always_comb begin
    tag_way_i  = tag_way_o;
    tag_read_i = tag_mem[tag_way_o];
    tag_full_i = 1'b1;
    for (int i = 0; i < WAYS_VC; i++) begin
      if (tag_mem[i].valid && tag_mem[i].tag == tag_addr_o[TAGMSB_VC:TAGLSB_VC]) begin
        tag_way_i  = INDEX_WAY_VC'(i);
        tag_read_i = tag_mem[i];
      end
      if (!tag_mem[i].valid) tag_full_i = 1'b0;
    end
  end

  assign data_rdata_i = data_mem[data_way_o];

  always @(posedge clk_i) begin
    if (load_junk) begin
      for (int i = 0; i < WAYS_VC; i++) begin
        tag_mem[i]  <= '{valid: 1'b1, dirty: 1'b1, tag: TW'(32'h0ABCDE0 + i)};
        data_mem[i] <= '0;
      end
    end else begin
      if (tag_req_o.we) tag_mem[tag_way_i] <= tag_write_o;
      if (data_we_o)    data_mem[data_way_o] <= data_wdata_o;
    end
  end

  function automatic logic [BB-1:0] dv(input int k);
    return {4{32'hD000_0000 + 32'(k)}};
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0; load_junk = 1'b1;
    @(negedge clk_i);
    load_junk = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic vv, input logic [AW-1:0] va,
                          input logic vd, input logic [BB-1:0] vdat, output int lat,
                          output logic hit, output logic dty, output logic [BB-1:0] dat);
    int t;
    lat = -1; hit = 1'b0; dty = 1'b0; dat = '0; t = 0;
    while (l1_req_ready_o !== 1'b1 && t < 40) begin @(negedge clk_i); t++; end
    l1_req_valid_i = 1'b1; l1_req_addr_i = a;
    l1_vic_valid_i = vv; l1_vic_addr_i = va; l1_vic_dirty_i = vd; l1_vic_data_i = vdat;
    @(negedge clk_i);
    l1_req_valid_i = 1'b0; l1_vic_valid_i = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (l1_rsp_valid_o === 1'b1) begin
        lat = n; hit = l1_rsp_hit_o; dty = l1_rsp_dirty_o; dat = l1_rsp_data_o;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_checks++; if (dut.r_state !== INIT) $display("FAIL reset_state: got %0d want %0d", dut.r_state, INIT); else n_pass++;
    n_checks++;
    if ({l1_req_ready_o, l1_rsp_valid_o, mem_wb_valid_o, tag_req_o.we, data_we_o} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
               {l1_req_ready_o, l1_rsp_valid_o, mem_wb_valid_o, tag_req_o.we, data_we_o});
    else n_pass++;
    rst_ni = 1'b1;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      if (l1_req_ready_o !== 1'b0) bad++;
      @(negedge clk_i);
    end
    n_checks++; if (bad !== 0) $display("FAIL init_ready_low: got %0d ready cycles want 0", bad); else n_pass++;
    n_checks++; if (l1_req_ready_o !== 1'b1) $display("FAIL init_ready_rise: got %b want 1", l1_req_ready_o); else n_pass++;
    bad = 0;
    for (int i = 0; i < WAYS_VC; i++) if (tag_mem[i].valid !== 1'b0) bad++;
    n_checks++; if (bad !== 0) $display("FAIL init_tags_cleared: got %0d valid entries want 0", bad); else n_pass++;
  endtask

  task automatic test_miss_then_hit();
    int lat; logic hit, dty; logic [BB-1:0] dat;
    vc_cache_tag_type exp;
    send_req(32'h2000, 1'b1, 32'h100, 1'b0, 128'hAAAA_5555_0123_4567_89AB_CDEF_FEDC_BA98, lat, hit, dty, dat);
    n_checks++; if (lat !== 4) $display("FAIL miss_vic_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if ({hit, dty} !== 2'b00) $display("FAIL miss_vic_hit_dirty: got %b want 00", {hit, dty}); else n_pass++;
    n_checks++; if (dat !== '0) $display("FAIL miss_vic_data: got %h want 0", dat); else n_pass++;
    exp = '{valid: 1'b1, dirty: 1'b0, tag: TW'(32'h10)};
    n_checks++; if (tag_mem[0] !== exp) $display("FAIL miss_vic_tag0: got %h want %h", tag_mem[0], exp); else n_pass++;

    send_req(32'h100, 1'b0, '0, 1'b0, '0, lat, hit, dty, dat);
    n_checks++; if (lat !== 3) $display("FAIL hit_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if ({hit, dty} !== 2'b10) $display("FAIL hit_flags: got %b want 10", {hit, dty}); else n_pass++;
    n_checks++;
    if (dat !== 128'hAAAA_5555_0123_4567_89AB_CDEF_FEDC_BA98)
      $display("FAIL hit_data: got %h want aaaa55550123456789abcdeffedcba98", dat);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (l1_rsp_valid_o !== 1'b0) $display("FAIL rsp_one_shot: got %b want 0", l1_rsp_valid_o); else n_pass++;
    n_checks++; if (tag_mem[0] !== '0) $display("FAIL hit_invalidate: got %h want 0", tag_mem[0]); else n_pass++;

    send_req(32'h3000, 1'b0, '0, 1'b0, '0, lat, hit, dty, dat);
    n_checks++; if (lat !== 2) $display("FAIL miss_novic_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (hit !== 1'b0) $display("FAIL miss_novic_hit: got %b want 0", hit); else n_pass++;
  endtask

  task automatic test_replacement();
    int lat; logic hit, dty; logic [BB-1:0] dat;
    for (int i = 0; i < 8; i++) begin
      send_req(32'h8000 + 32'(i * 16), 1'b1, 32'h1000 + 32'(i * 16), 1'b0, dv(i), lat, hit, dty, dat);
      n_checks++; if (lat !== 4) $display("FAIL fill_latency_%0d: got %0d want 4", i, lat); else n_pass++;
    end
    @(negedge clk_i);
    n_checks++; if (tag_full_i !== 1'b1) $display("FAIL fill_full: got %b want 1", tag_full_i); else n_pass++;
    send_req(32'h8100, 1'b1, 32'h1100, 1'b0, dv(8), lat, hit, dty, dat);
    @(negedge clk_i);
    n_checks++; if (tag_mem[0].tag !== TW'(32'h110)) $display("FAIL repl9_way0: got %h want 110", tag_mem[0].tag); else n_pass++;
    n_checks++; if (dut.r_repl_ptr !== 3'd1) $display("FAIL repl9_ptr: got %0d want 1", dut.r_repl_ptr); else n_pass++;
    send_req(32'h8110, 1'b1, 32'h1110, 1'b0, dv(9), lat, hit, dty, dat);
    @(negedge clk_i);
    n_checks++; if (tag_mem[1].tag !== TW'(32'h111)) $display("FAIL repl10_way1: got %h want 111", tag_mem[1].tag); else n_pass++;
    n_checks++; if (data_mem[1] !== dv(9)) $display("FAIL repl10_data: got %h want %h", data_mem[1], dv(9)); else n_pass++;
    n_checks++; if (tag_mem[2].tag !== TW'(32'h102)) $display("FAIL repl10_way2_kept: got %h want 102", tag_mem[2].tag); else n_pass++;
  endtask

  task automatic test_hit_swap();
    int lat; logic hit, dty; logic [BB-1:0] dat;
    vc_cache_tag_type exp;
    send_req(32'h1050, 1'b1, 32'h4440, 1'b1, dv(77), lat, hit, dty, dat);
    n_checks++; if (lat !== 3) $display("FAIL swap_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if ({hit, dty} !== 2'b10) $display("FAIL swap_flags: got %b want 10", {hit, dty}); else n_pass++;
    n_checks++; if (dat !== dv(5)) $display("FAIL swap_data: got %h want %h", dat, dv(5)); else n_pass++;
    @(negedge clk_i);
    exp = '{valid: 1'b1, dirty: 1'b1, tag: TW'(32'h444)};
    n_checks++; if (tag_mem[5] !== exp) $display("FAIL swap_tag5: got %h want %h", tag_mem[5], exp); else n_pass++;
    n_checks++; if (data_mem[5] !== dv(77)) $display("FAIL swap_data5: got %h want %h", data_mem[5], dv(77)); else n_pass++;
  endtask

  task automatic test_dirty_wb();
    int lat, wb_cycles, wb_bad, t; logic hit, dty; logic [BB-1:0] dat;
    vc_cache_tag_type exp;
    do_reset();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++)
      send_req(32'h9000 + 32'(i * 16), 1'b1, 32'h2000 + 32'(i * 16), 1'b1, dv(200 + i), lat, hit, dty, dat);
    mem_wb_ready_i = 1'b0;
    t = 0;
    while (l1_req_ready_o !== 1'b1 && t < 40) begin @(negedge clk_i); t++; end
    l1_req_valid_i = 1'b1; l1_req_addr_i = 32'h9800;
    l1_vic_valid_i = 1'b1; l1_vic_addr_i = 32'h5550; l1_vic_dirty_i = 1'b1; l1_vic_data_i = dv(99);
    @(negedge clk_i);
    l1_req_valid_i = 1'b0; l1_vic_valid_i = 1'b0;
    lat = -1; wb_cycles = 0; wb_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 6) mem_wb_ready_i = 1'b1;
      if (mem_wb_valid_o === 1'b1) begin
        wb_cycles++;
        if (mem_wb_addr_o !== 32'h2000 || mem_wb_data_o !== dv(200)) wb_bad++;
      end
      if (l1_rsp_valid_o === 1'b1 && lat < 0) lat = n;
      @(negedge clk_i);
    end
    n_checks++; if (wb_cycles !== 4) $display("FAIL wb_hold_cycles: got %0d want 4", wb_cycles); else n_pass++;
    n_checks++; if (wb_bad !== 0) $display("FAIL wb_stable: got %0d bad cycles want 0", wb_bad); else n_pass++;
    n_checks++; if (lat !== 8) $display("FAIL wb_latency: got %0d want 8", lat); else n_pass++;
    exp = '{valid: 1'b1, dirty: 1'b1, tag: TW'(32'h555)};
    n_checks++; if (tag_mem[0] !== exp) $display("FAIL wb_insert_tag: got %h want %h", tag_mem[0], exp); else n_pass++;
    n_checks++; if (data_mem[0] !== dv(99)) $display("FAIL wb_insert_data: got %h want %h", data_mem[0], dv(99)); else n_pass++;
  endtask

  task automatic test_reset_during_wb();
    int t, rsp_seen;
    mem_wb_ready_i = 1'b0;
    t = 0;
    while (l1_req_ready_o !== 1'b1 && t < 40) begin @(negedge clk_i); t++; end
    l1_req_valid_i = 1'b1; l1_req_addr_i = 32'h9900;
    l1_vic_valid_i = 1'b1; l1_vic_addr_i = 32'h6660; l1_vic_dirty_i = 1'b1; l1_vic_data_i = dv(98);
    @(negedge clk_i);
    l1_req_valid_i = 1'b0; l1_vic_valid_i = 1'b0;
    t = 0;
    while (mem_wb_valid_o !== 1'b1 && t < 10) begin @(negedge clk_i); t++; end
    n_checks++; if (mem_wb_addr_o !== 32'h2010) $display("FAIL rwb_addr: got %h want 00002010", mem_wb_addr_o); else n_pass++;
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_checks++; if (mem_wb_valid_o !== 1'b0) $display("FAIL rwb_valid_drop: got %b want 0", mem_wb_valid_o); else n_pass++;
    n_checks++; if (dut.r_state !== INIT) $display("FAIL rwb_state: got %0d want %0d", dut.r_state, INIT); else n_pass++;
    rst_ni = 1'b1;
    rsp_seen = 0;
    for (int n = 0; n < 12; n++) begin
      if (l1_rsp_valid_o !== 1'b0) rsp_seen++;
      @(negedge clk_i);
    end
    mem_wb_ready_i = 1'b1;
    n_checks++; if (rsp_seen !== 0) $display("FAIL rwb_no_rsp: got %0d pulses want 0", rsp_seen); else n_pass++;
    n_checks++; if (l1_req_ready_o !== 1'b1) $display("FAIL rwb_reinit_ready: got %b want 1", l1_req_ready_o); else n_pass++;
  endtask

  initial begin
    rst_ni = 1'b0; load_junk = 1'b0; mem_wb_ready_i = 1'b1;
    l1_req_valid_i = 1'b0; l1_req_addr_i = '0;
    l1_vic_valid_i = 1'b0; l1_vic_addr_i = '0; l1_vic_dirty_i = 1'b0; l1_vic_data_i = '0;
    test_reset();
    test_miss_then_hit();
    test_replacement();
    test_hit_swap();
    test_dirty_wb();
    test_reset_during_wb();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
